// File: rtl/traffic_generator_pkg.sv
// Shared definitions for the traffic generator and the matching collector:
// header field layout, FSM state encoding and destination LFSR constants.
package traffic_generator_pkg;

    // Header layout inside a packet word; bits above TG_HDR_W are always zero
    localparam int TG_ID_W    = 6;
    localparam int TG_PID_W   = 10;
    localparam int TG_SRC_LSB = 0;
    localparam int TG_PID_LSB = TG_SRC_LSB + TG_ID_W;
    localparam int TG_DST_LSB = TG_PID_LSB + TG_PID_W;
    localparam int TG_HDR_W   = TG_DST_LSB + TG_ID_W;

    // Injection FSM encoding
    localparam logic [1:0] TG_ST_GAP     = 2'd0;
    localparam logic [1:0] TG_ST_REQ     = 2'd1;
    localparam logic [1:0] TG_ST_RELEASE = 2'd2;
    localparam logic [1:0] TG_ST_DONE    = 2'd3;

    // Destination LFSR: taps 16,14,13,11 in right-shifting Fibonacci form,
    // so the feedback is the parity of bits 0, 2, 3 and 5
    localparam logic [15:0] TG_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] TG_LFSR_TAPS = 16'h002D;

    // Header as it sits in the low bits of PacketOut
    typedef struct packed {
        logic [TG_ID_W-1:0]  dest;
        logic [TG_PID_W-1:0] pid;
        logic [TG_ID_W-1:0]  src;
    } tg_header_t;

endpackage

// File: rtl/traffic_generator_lfsr.sv
// tg_lfsr16: 16-bit Fibonacci LFSR that steps only when 'advance' is high.
// Used by traffic_generator to pick random destinations.
module tg_lfsr16
    import traffic_generator_pkg::*;
#(
    parameter logic [15:0] SEED = TG_LFSR_SEED,
    parameter logic [15:0] TAPS = TG_LFSR_TAPS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    // Shift right by one with the tap parity entering at the top
    always_comb begin
        feedback = ^(lfsr_q & TAPS);
        lfsr_d   = advance ? {feedback, lfsr_q[15:1]} : lfsr_q;
    end

    // Register restarts from the seed on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/traffic_generator.sv
// traffic_generator: injects header-only packets into a router local port
// using a request/grant handshake, with a programmable idle gap and budget.
// Optional feature macro: TG_RANDOM_DEST_EN (random destination from an LFSR;
// when undefined every packet goes to destID).
module traffic_generator
    import traffic_generator_pkg::*;
#(
    parameter logic [5:0] routerID   = 6'b000_000,
    parameter int         dataWidth  = 32,
    parameter int         dim        = 4,
    parameter logic [5:0] destID     = 6'b000_001,
    parameter int         injectGap  = 4,
    parameter int         numPackets = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 DnStrFull,
    input  logic                 GntDnStr,
    output logic [dataWidth-1:0] PacketOut,
    output logic                 ReqDnStr,
    output logic                 done,
    output logic [31:0]          SentCount
);

    localparam int GAP_W = (injectGap > 1) ? $clog2(injectGap + 1) : 1;

    // A mesh whose coordinates need more than the 6-bit ID fields cannot be
    // addressed by this header; such a configuration elaborates to nothing extra
    if (2 * $clog2(dim) > TG_ID_W) begin : g_mesh_exceeds_id_field
    end

    logic [1:0]           state_q, state_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [TG_PID_W-1:0]  pid_q, pid_d;
    logic [31:0]          sent_q, sent_d;
    logic [dataWidth-1:0] pkt_q, pkt_d;
    logic                 req_q, req_d;
    logic                 done_q, done_d;

    logic                 build;
    logic                 budget_left;
    logic [TG_ID_W-1:0]   next_dest;
    tg_header_t           hdr;

`ifdef TG_RANDOM_DEST_EN
    logic [15:0] lfsr_value;
    logic        unused_lfsr_hi;

    tg_lfsr16 #(
        .SEED (TG_LFSR_SEED ^ {10'b0, routerID}),
        .TAPS (TG_LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (build),
        .value   (lfsr_value)
    );

    // Never address ourselves: a random pick equal to our own ID goes to destID
    assign next_dest      = (lfsr_value[5:0] == routerID) ? destID : lfsr_value[5:0];
    assign unused_lfsr_hi = ^lfsr_value[15:6];
`else
    assign next_dest = destID;
`endif

    assign budget_left = (numPackets == 0) || (sent_q != 32'(numPackets));

    // Next packet word, assembled from the current ID and chosen destination
    always_comb begin
        hdr      = '0;
        hdr.dest = next_dest;
        hdr.pid  = pid_q;
        hdr.src  = routerID;
    end

    // Injection FSM: gap countdown, request until granted, wait for grant release
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pid_d   = pid_q;
        sent_d  = sent_q;
        pkt_d   = pkt_q;
        req_d   = req_q;
        done_d  = done_q;
        build   = 1'b0;

        case (state_q)
            TG_ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (enable && !DnStrFull && budget_left) begin
                    build   = 1'b1;
                    pkt_d   = dataWidth'(hdr);
                    req_d   = 1'b1;
                    state_d = TG_ST_REQ;
                end
            end
            TG_ST_REQ: begin
                if (GntDnStr) begin
                    req_d   = 1'b0;
                    pid_d   = pid_q + 1'b1;
                    sent_d  = sent_q + 32'd1;
                    state_d = TG_ST_RELEASE;
                end
            end
            TG_ST_RELEASE: begin
                if (!GntDnStr) begin
                    if ((numPackets != 0) && (sent_q == 32'(numPackets))) begin
                        done_d  = 1'b1;
                        state_d = TG_ST_DONE;
                    end else begin
                        gap_d   = GAP_W'(injectGap);
                        state_d = TG_ST_GAP;
                    end
                end
            end
            TG_ST_DONE: begin
                req_d  = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                state_d = TG_ST_GAP;
                req_d   = 1'b0;
            end
        endcase
    end

    // State registers; reset drops an outstanding request without counting it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TG_ST_GAP;
            gap_q   <= GAP_W'(injectGap);
            pid_q   <= '0;
            sent_q  <= '0;
            pkt_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            pid_q   <= pid_d;
            sent_q  <= sent_d;
            pkt_q   <= pkt_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end

    assign PacketOut = pkt_q;
    assign ReqDnStr  = req_q;
    assign done      = done_q;
    assign SentCount = sent_q;

endmodule

// File: tb/tb_traffic_generator.sv
// Testbench for traffic_generator. Instance A: routerID 5, destID 9, gap 4,
// three packets. Instance B: routerID 0, destID 1, back-to-back, unlimited.
module tb_traffic_generator;

    localparam logic [5:0] A_RID = 6'h05;
    localparam logic [5:0] A_DID = 6'h09;
    localparam logic [5:0] B_RID = 6'h00;
    localparam logic [5:0] B_DID = 6'h01;

    logic        clk;
    logic        rst_a, en_a, full_a, gnt_a;
    logic [31:0] pkt_a, cnt_a;
    logic        req_a, done_a;
    logic        rst_b, en_b, full_b, gnt_b;
    logic [31:0] pkt_b, cnt_b;
    logic        req_b, done_b;

    int checks = 0;
    int errors = 0;

    traffic_generator #(
        .routerID(A_RID), .dataWidth(32), .dim(4), .destID(A_DID),
        .injectGap(4), .numPackets(3)
    ) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .DnStrFull(full_a),
        .GntDnStr(gnt_a), .PacketOut(pkt_a), .ReqDnStr(req_a),
        .done(done_a), .SentCount(cnt_a)
    );

    traffic_generator #(
        .routerID(B_RID), .dataWidth(32), .dim(4), .destID(B_DID),
        .injectGap(0), .numPackets(0)
    ) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .DnStrFull(full_b),
        .GntDnStr(gnt_b), .PacketOut(pkt_b), .ReqDnStr(req_b),
        .done(done_b), .SentCount(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Destination of the n-th packet since reset (0-based)
    function automatic logic [5:0] model_dest(input logic [5:0] rid, input logic [5:0] did, input int n);
`ifdef TG_RANDOM_DEST_EN
        int unsigned s;
        int unsigned b;
        int unsigned d;
        s = 32'hACE1 ^ 32'(rid);
        for (int i = 0; i < n; i++) begin
            b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
            s = (s >> 1) | (b << 15);
        end
        d = s % 64;
        return (d == 32'(rid)) ? did : 6'(d);
`else
        return did;
`endif
    endfunction

    // Whole packet word for the n-th packet since reset
    function automatic logic [31:0] model_packet(input logic [5:0] rid, input logic [5:0] did, input int n);
        int unsigned w;
        w = 32'(model_dest(rid, did, n)) * 65536 + 32'(n % 1024) * 64 + 32'(rid);
        return w;
    endfunction

    task automatic wait_req_a(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (req_a === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_req_b(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (req_b === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_reset_a();
        rst_a = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; en_a = 1'b0; full_a = 1'b0; gnt_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; full_b = 1'b0; gnt_b = 1'b0;
        tick(); tick(); tick();
        checks++; if (req_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_a: got %b expected 0", req_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_done_a: got %b expected 0", done_a); end
        checks++; if (cnt_a !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt_a: got %0d expected 0", cnt_a); end
        checks++; if (pkt_a !== 32'd0) begin errors++; $display("[TB] FAIL reset_pkt_a: got %h expected 0", pkt_a); end
        checks++; if (req_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_b: got %b expected 0", req_b); end
        checks++; if (done_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_done_b: got %b expected 0", done_b); end
        checks++; if (cnt_b !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt_b: got %0d expected 0", cnt_b); end
        checks++; if (pkt_b !== 32'd0) begin errors++; $display("[TB] FAIL reset_pkt_b: got %h expected 0", pkt_b); end
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_basic_sequence();
        bit          seen;
        int          lat;
        int          req_in_done;
        logic [31:0] exp_pkt;
        logic [31:0] lit [3];
        lit[0] = 32'h0009_0005; lit[1] = 32'h0009_0045; lit[2] = 32'h0009_0085;
        en_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_req_a(40, seen);
            checks++;
            if (!seen) begin errors++; $display("[TB] FAIL basic_req_timeout: got req=%b expected 1 (packet %0d)", req_a, k); end
`ifdef TG_RANDOM_DEST_EN
            exp_pkt = model_packet(A_RID, A_DID, k);
`else
            exp_pkt = lit[k];
`endif
            checks++; if (pkt_a !== exp_pkt) begin errors++; $display("[TB] FAIL basic_pkt: got %h expected %h", pkt_a, exp_pkt); end
            checks++; if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_early: got %b expected 0", done_a); end
            lat = $urandom_range(1, 3);
            for (int j = 0; j < lat; j++) begin
                tick();
                checks++; if (req_a !== 1'b1 || pkt_a !== exp_pkt) begin errors++; $display("[TB] FAIL basic_req_hold: got req=%b pkt=%h expected 1/%h", req_a, pkt_a, exp_pkt); end
            end
            gnt_a = 1'b1;
            tick();
            gnt_a = 1'b0;
            checks++; if (req_a !== 1'b0) begin errors++; $display("[TB] FAIL basic_req_drop: got %b expected 0", req_a); end
            checks++; if (cnt_a !== 32'(k + 1)) begin errors++; $display("[TB] FAIL basic_cnt: got %0d expected %0d", cnt_a, k + 1); end
        end
        for (int i = 0; i < 10; i++) begin
            if (done_a === 1'b1) break;
            tick();
        end
        checks++; if (done_a !== 1'b1) begin errors++; $display("[TB] FAIL basic_done: got %b expected 1", done_a); end
        checks++; if (cnt_a !== 32'd3) begin errors++; $display("[TB] FAIL basic_final_cnt: got %0d expected 3", cnt_a); end
        req_in_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_a !== 1'b0 || done_a !== 1'b1) req_in_done++;
        end
        checks++; if (req_in_done !== 0) begin errors++; $display("[TB] FAIL basic_done_terminal: got %0d bad cycles expected 0", req_in_done); end
    endtask

    task automatic test_full_blocking();
        int hold;
        pulse_reset_a();
        full_a = 1'b1;
        en_a   = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            checks++; if (req_a !== 1'b0) begin errors++; $display("[TB] FAIL full_block_req: got %b expected 0 (cycle %0d)", req_a, i); end
        end
        full_a = 1'b0;
        tick();
        checks++; if (req_a !== 1'b1) begin errors++; $display("[TB] FAIL full_release_req: got %b expected 1", req_a); end
        checks++; if (pkt_a !== model_packet(A_RID, A_DID, 0)) begin errors++; $display("[TB] FAIL full_pkt: got %h expected %h", pkt_a, model_packet(A_RID, A_DID, 0)); end
        full_a = 1'b1;
        hold = $urandom_range(2, 6);
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++; if (req_a !== 1'b1) begin errors++; $display("[TB] FAIL full_in_req_hold: got %b expected 1", req_a); end
        end
        gnt_a = 1'b1;
        tick();
        gnt_a  = 1'b0;
        full_a = 1'b0;
        checks++; if (cnt_a !== 32'd1) begin errors++; $display("[TB] FAIL full_cnt: got %0d expected 1", cnt_a); end
    endtask

    task automatic test_enable_drop();
        bit seen;
        int lat;
        int stray;
        en_a = 1'b1;
        wait_req_a(20, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL enable_req_timeout: got req=%b expected 1", req_a); end
        checks++; if (pkt_a !== model_packet(A_RID, A_DID, 1)) begin errors++; $display("[TB] FAIL enable_pkt1: got %h expected %h", pkt_a, model_packet(A_RID, A_DID, 1)); end
        en_a = 1'b0;
        lat = $urandom_range(1, 4);
        for (int i = 0; i < lat; i++) begin
            tick();
            checks++; if (req_a !== 1'b1) begin errors++; $display("[TB] FAIL enable_req_hold: got %b expected 1", req_a); end
        end
        gnt_a = 1'b1;
        tick();
        gnt_a = 1'b0;
        checks++; if (cnt_a !== 32'd2) begin errors++; $display("[TB] FAIL enable_cnt: got %0d expected 2", cnt_a); end
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (req_a !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL enable_low_req: got %0d req cycles expected 0", stray); end
        en_a = 1'b1;
        wait_req_a(5, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL enable_resume: got req=%b expected 1", req_a); end
        checks++; if (pkt_a !== model_packet(A_RID, A_DID, 2)) begin errors++; $display("[TB] FAIL enable_pkt2: got %h expected %h", pkt_a, model_packet(A_RID, A_DID, 2)); end
        gnt_a = 1'b1;
        tick();
        gnt_a = 1'b0;
        checks++; if (cnt_a !== 32'd3) begin errors++; $display("[TB] FAIL enable_cnt3: got %0d expected 3", cnt_a); end
    endtask

    task automatic test_reset_mid_req();
        bit seen;
        pulse_reset_a();
        en_a = 1'b1;
        full_a = 1'b0;
        wait_req_a(20, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL midreset_req_timeout: got req=%b expected 1", req_a); end
        #2;
        rst_a = 1'b1;
        #1;
        checks++; if (req_a !== 1'b0) begin errors++; $display("[TB] FAIL midreset_req_drop: got %b expected 0", req_a); end
        checks++; if (cnt_a !== 32'd0) begin errors++; $display("[TB] FAIL midreset_cnt: got %0d expected 0", cnt_a); end
        tick();
        rst_a = 1'b0;
        wait_req_a(20, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL midreset_restart: got req=%b expected 1", req_a); end
        checks++; if (pkt_a !== model_packet(A_RID, A_DID, 0)) begin errors++; $display("[TB] FAIL midreset_pkt: got %h expected %h", pkt_a, model_packet(A_RID, A_DID, 0)); end
        gnt_a = 1'b1;
        tick();
        gnt_a = 1'b0;
        checks++; if (cnt_a !== 32'd1) begin errors++; $display("[TB] FAIL midreset_cnt1: got %0d expected 1", cnt_a); end
    endtask

    task automatic test_back_to_back();
        bit          seen;
        int          lat;
        logic [31:0] exp_pkt;
        logic [9:0]  pid_field;
        en_b   = 1'b1;
        full_b = 1'b0;
        for (int n = 0; n < 1030; n++) begin
            wait_req_b(8, seen);
            checks++;
            if (!seen) begin errors++; $display("[TB] FAIL b2b_req_timeout: got req=%b expected 1 (packet %0d)", req_b, n); break; end
            exp_pkt = model_packet(B_RID, B_DID, n);
            checks++; if (pkt_b !== exp_pkt) begin errors++; $display("[TB] FAIL b2b_pkt: got %h expected %h (packet %0d)", pkt_b, exp_pkt, n); end
`ifdef TG_RANDOM_DEST_EN
            checks++; if (pkt_b[21:16] === B_RID) begin errors++; $display("[TB] FAIL b2b_self_dest: got %h expected not %h", pkt_b[21:16], B_RID); end
`endif
            pid_field = pkt_b[15:6];
            if (n == 1023) begin
                checks++; if (pid_field !== 10'd1023) begin errors++; $display("[TB] FAIL b2b_pid_max: got %0d expected 1023", pid_field); end
            end
            if (n == 1024) begin
                checks++; if (pid_field !== 10'd0) begin errors++; $display("[TB] FAIL b2b_pid_wrap: got %0d expected 0", pid_field); end
            end
            lat = $urandom_range(0, 2);
            for (int j = 0; j < lat; j++) tick();
            gnt_b = 1'b1;
            tick();
            gnt_b = 1'b0;
            checks++; if (req_b !== 1'b0) begin errors++; $display("[TB] FAIL b2b_req_drop: got %b expected 0", req_b); end
            checks++; if (cnt_b !== 32'(n + 1)) begin errors++; $display("[TB] FAIL b2b_cnt: got %0d expected %0d", cnt_b, n + 1); end
            tick();
            checks++; if (req_b !== 1'b0) begin errors++; $display("[TB] FAIL b2b_release_low: got %b expected 0", req_b); end
            tick();
            checks++; if (req_b !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rise_timing: got %b expected 1 (packet %0d)", req_b, n); end
        end
        checks++; if (done_b !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done: got %b expected 0", done_b); end
        checks++; if (cnt_b !== 32'd1030) begin errors++; $display("[TB] FAIL b2b_total: got %0d expected 1030", cnt_b); end
    endtask

    initial begin
        test_reset();
        test_basic_sequence();
        test_full_blocking();
        test_enable_drop();
        test_reset_mid_req();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
